// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - hardware LIFO for the CPU data stack with registered top and sticky flags
module stack_unit #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             init,
  input  logic             STACK_push_flag,
  input  logic [WIDTH-1:0] STACK_push_value,
  input  logic             STACK_pop_flag,
  input  logic             STACK_clear_flag,
  output logic [WIDTH-1:0] STACK_TOP,
  output logic [15:0]      STACK_AMOUNT,
  output logic             STACK_empty,
  output logic             STACK_full,
  output logic             STACK_overflow,
  output logic             STACK_underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_top;
  logic             r_ovf;
  logic             r_unf;

  logic             w_full;
  logic             w_empty;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_idx_m1;
  logic [AW-1:0]    w_idx_m2;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_top_nxt;
  logic             w_ovf_nxt;
  logic             w_unf_nxt;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  // Index arithmetic is modulo DEPTH; only used when the count guarantees a valid slot.
  assign w_idx_m1 = r_count[AW-1:0] - AW'(1);
  assign w_idx_m2 = r_count[AW-1:0] - AW'(2);

  always_comb begin
    w_we        = 1'b0;
    w_waddr     = r_count[AW-1:0];
    w_count_nxt = r_count;
    w_top_nxt   = r_top;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    if (STACK_clear_flag) begin
      w_count_nxt = '0;
      w_top_nxt   = '0;
      w_ovf_nxt   = 1'b0;
      w_unf_nxt   = 1'b0;
    end else begin
      case ({STACK_push_flag, STACK_pop_flag})
        2'b10: begin
          if (!w_full) begin
            w_we        = 1'b1;
            w_top_nxt   = STACK_push_value;
            w_count_nxt = r_count + CW'(1);
          end else begin
            w_ovf_nxt = 1'b1;
          end
        end
        2'b01: begin
          if (r_count > CW'(1)) begin
            w_top_nxt   = r_mem[w_idx_m2];
            w_count_nxt = r_count - CW'(1);
          end else if (r_count == CW'(1)) begin
            w_top_nxt   = '0;
            w_count_nxt = '0;
          end else begin
            w_unf_nxt = 1'b1;
          end
        end
        2'b11: begin
          // Replace-top; on an empty stack the value is consumed in flight.
          if (!w_empty) begin
            w_we      = 1'b1;
            w_waddr   = w_idx_m1;
            w_top_nxt = STACK_push_value;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (init && w_we) begin
      r_mem[w_waddr] <= STACK_push_value;
    end
  end

  always_ff @(posedge clock or negedge init) begin
    if (!init) begin
      r_count <= '0;
      r_top   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_top   <= w_top_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  assign STACK_TOP       = r_top;
  assign STACK_AMOUNT    = 16'(r_count);
  assign STACK_empty     = w_empty;
  assign STACK_full      = w_full;
  assign STACK_overflow  = r_ovf;
  assign STACK_underflow = r_unf;

endmodule

// File: tb/tb_stack_unit.sv
// tb/tb_stack_unit.sv - scoreboard bench for stack_unit against a queue-based LIFO model
module tb_stack_unit;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clock;
  logic             init;
  logic             push_flag;
  logic [WIDTH-1:0] push_value;
  logic             pop_flag;
  logic             clear_flag;
  logic [WIDTH-1:0] top;
  logic [15:0]      amount;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;

  stack_unit #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock            (clock),
    .init             (init),
    .STACK_push_flag  (push_flag),
    .STACK_push_value (push_value),
    .STACK_pop_flag   (pop_flag),
    .STACK_clear_flag (clear_flag),
    .STACK_TOP        (top),
    .STACK_AMOUNT     (amount),
    .STACK_empty      (empty),
    .STACK_full       (full),
    .STACK_overflow   (ovf),
    .STACK_underflow  (unf)
  );

  typedef struct {
    logic [31:0] top;
    logic [31:0] amount;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_stk[$];
  logic        model_ovf;
  logic        model_unf;
  int          n_vec;
  int          n_err;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk("top",       top,    e.top);
    chk("amount",    {16'd0, amount}, e.amount);
    chk("empty",     {31'd0, empty},  {31'd0, e.empty});
    chk("full",      {31'd0, full},   {31'd0, e.full});
    chk("overflow",  {31'd0, ovf},    {31'd0, e.ovf});
    chk("underflow", {31'd0, unf},    {31'd0, e.unf});
  endtask

  function automatic exp_t model_view();
    exp_t e;
    e.amount = model_stk.size();
    e.top    = (model_stk.size() > 0) ? model_stk[$] : 32'd0;
    e.empty  = (model_stk.size() == 0);
    e.full   = (model_stk.size() == DEPTH);
    e.ovf    = model_ovf;
    e.unf    = model_unf;
    return e;
  endfunction

  function automatic void model_reset();
    model_stk.delete();
    model_ovf = 1'b0;
    model_unf = 1'b0;
  endfunction

  task automatic step(input logic p, input logic q, input logic c, input logic [31:0] v);
    @(negedge clock);
    push_flag  = p;
    pop_flag   = q;
    clear_flag = c;
    push_value = v;
    if (c) begin
      model_reset();
    end else if (p && !q) begin
      if (model_stk.size() < DEPTH) model_stk.push_back(v);
      else model_ovf = 1'b1;
    end else if (q && !p) begin
      if (model_stk.size() > 0) void'(model_stk.pop_back());
      else model_unf = 1'b1;
    end else if (p && q) begin
      if (model_stk.size() > 0) model_stk[model_stk.size()-1] = v;
    end
    exp_q.push_back(model_view());
  endtask

  always @(posedge clock) begin
    #2;
    if (exp_q.size() > 0) chk_all(exp_q.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t rst_e;
    n_vec = 0;
    n_err = 0;
    model_reset();
    rst_e = model_view();
    init = 1'b0;
    push_flag = 1'b0;
    pop_flag = 1'b0;
    clear_flag = 1'b0;
    push_value = '0;
    #1;
    chk_all(rst_e);
    @(negedge clock);
    @(negedge clock);
    init = 1'b1;

    step(1, 0, 0, 32'hDEADBEEF);
    step(0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) step(1, 0, 0, i);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 7);
    step(0, 0, 1, 0);
    step(1, 0, 0, 32'h10);
    step(1, 0, 0, 32'h20);
    step(1, 1, 0, 32'h99);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 32'h55);
    step(0, 0, 0, 0);

    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'hA0 + i);
    step(1, 0, 0, 32'hA3);
    @(posedge clock);
    #3;
    init = 1'b0;
    model_reset();
    #1;
    chk_all(model_view());
    @(posedge clock);
    #1;
    chk_all(model_view());
    @(negedge clock);
    init = 1'b1;
    push_flag = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 32'hBEEF);

    for (int i = 0; i < 400; i++) begin
      int r;
      logic p, q, c;
      r = $urandom_range(0, 99);
      c = (r < 3);
      p = ($urandom_range(0, 9) < 5);
      q = ($urandom_range(0, 9) < 4);
      step(p, q, c, $urandom);
    end
    step(0, 0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
